hazard_forward_ctrl: RTL

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_forward_ctrl_pkg.sv | 25 ++
 rtl/hazard_forward_ctrl_fwd_select.sv | 22 ++
 rtl/hazard_forward_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_forward_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StStall   = 2'b01,
    StMemWait = 2'b10
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a register-writing stage targets a source of the ID instruction.
  function automatic logic writer_hits(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
    return we && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forwarding-mux select for one EX source operand; MEM result beats WB data.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic       mem_regwrite_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_regwrite_i,
  input  logic [4:0] wb_rd_i,
  input  logic [4:0] src_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_regwrite_i && (mem_rd_i != REG_ZERO) && (mem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard, branch-flush, memory-freeze and forwarding control.
// Build option: define HAZARD_FWD_EN to enable operand forwarding.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_Rs_In,
  input  logic [4:0]       ID_Rt_In,
  input  logic             ID_UsesRt_In,
  input  logic [4:0]       EX_Rs_In,
  input  logic [4:0]       EX_Rt_In,
  input  logic             EX_MemRead_In,
  input  logic             EX_RegWrite_In,
  input  logic [4:0]       EX_Rd_In,
  input  logic             MEM_RegWrite_In,
  input  logic [4:0]       MEM_Rd_In,
  input  logic             WB_RegWrite_In,
  input  logic [4:0]       WB_Rd_In,
  input  logic             Branch_Taken_In,
  input  logic             Mem_Req_In,
  input  logic             Mem_Ready_In,
  output logic [1:0]       ForwardA_Out,
  output logic [1:0]       ForwardB_Out,
  output logic             PC_Write_Out,
  output logic             IFID_Write_Out,
  output logic             IDEX_Bubble_Out,
  output logic             IFID_Flush_Out,
  output logic             Pipe_Freeze_Out,
  output logic [CNT_W-1:0] Stall_Count_Out
);

`ifdef HAZARD_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_total_q, stall_total_d;

  logic       ex_hit, mem_hit, wb_hit;
  logic [1:0] need_fwd, need_nofwd, need_n;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_write, ifid_write, bubble, flush, freeze;

  fwd_select u_fwd_a (
    .mem_regwrite_i (MEM_RegWrite_In),
    .mem_rd_i       (MEM_Rd_In),
    .wb_regwrite_i  (WB_RegWrite_In),
    .wb_rd_i        (WB_Rd_In),
    .src_i          (EX_Rs_In),
    .sel_o          (fwd_a)
  );

  fwd_select u_fwd_b (
    .mem_regwrite_i (MEM_RegWrite_In),
    .mem_rd_i       (MEM_Rd_In),
    .wb_regwrite_i  (WB_RegWrite_In),
    .wb_rd_i        (WB_Rd_In),
    .src_i          (EX_Rt_In),
    .sel_o          (fwd_b)
  );

  always_comb begin
    ex_hit  = writer_hits(EX_RegWrite_In, EX_Rd_In, ID_Rs_In, ID_Rt_In, ID_UsesRt_In);
    mem_hit = writer_hits(MEM_RegWrite_In, MEM_Rd_In, ID_Rs_In, ID_Rt_In, ID_UsesRt_In);
    wb_hit  = writer_hits(WB_RegWrite_In, WB_Rd_In, ID_Rs_In, ID_Rt_In, ID_UsesRt_In);

    // With forwarding only a load in EX cannot be bypassed in time.
    need_fwd = (ex_hit && EX_MemRead_In) ? 2'd1 : 2'd0;
    if (ex_hit) begin
      need_nofwd = 2'd3;
    end else if (mem_hit) begin
      need_nofwd = 2'd2;
    end else if (wb_hit) begin
      need_nofwd = 2'd1;
    end else begin
      need_nofwd = 2'd0;
    end
    need_n = FwdEn ? need_fwd : need_nofwd;
  end

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    freeze     = 1'b0;
    // The cycle that releases a memory wait behaves as the saved state.
    eff_state  = (state_q == StMemWait) ? saved_q : state_q;

    if (Mem_Req_In && !Mem_Ready_In) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (state_q != StMemWait) saved_d = state_q;
      state_d = StMemWait;
    end else if ((state_q == StMemWait) && !Mem_Ready_In) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (Branch_Taken_In) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      cnt_d   = 2'd0;
      state_d = StRun;
    end else if (eff_state == StStall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
      cnt_d      = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
      state_d    = (cnt_q <= 2'd1) ? StRun : StStall;
    end else if (need_n != 2'd0) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
      cnt_d      = need_n - 2'd1;
      state_d    = (need_n > 2'd1) ? StStall : StRun;
    end else begin
      state_d = StRun;
    end

    stall_total_d = stall_total_q;
    if (!pc_write && (stall_total_q != {CNT_W{1'b1}})) begin
      stall_total_d = stall_total_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      saved_q       <= StRun;
      cnt_q         <= 2'd0;
      stall_total_q <= '0;
    end else begin
      state_q       <= state_d;
      saved_q       <= saved_d;
      cnt_q         <= cnt_d;
      stall_total_q <= stall_total_d;
    end
  end

  // Outputs fall back to a quiet, free-running pipeline while reset is held.
  always_comb begin
    ForwardA_Out    = (reset || !FwdEn) ? FWD_REG : fwd_a;
    ForwardB_Out    = (reset || !FwdEn) ? FWD_REG : fwd_b;
    PC_Write_Out    = reset | pc_write;
    IFID_Write_Out  = reset | ifid_write;
    IDEX_Bubble_Out = !reset & bubble;
    IFID_Flush_Out  = !reset & flush;
    Pipe_Freeze_Out = !reset & freeze;
    Stall_Count_Out = stall_total_q;
  end

endmodule
